demux_1to8_capture: RTL and testbench

DEMUX_1TO8_CAPTURE -- requirements
Module: demux_1to8_capture

---
 rtl/demux_1to8_capture_pkg.sv | 9 +
 rtl/demux_1to8_capture_if.sv | 25 ++
 rtl/demux_1to8_capture_decoder.sv | 13 +
 rtl/demux_1to8_capture.sv | 72 +++++++
 tb/tb_demux_1to8_capture.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/demux_1to8_capture_pkg.sv
// Shared FSM encoding and default width for the serial-to-word capture demux.
package demux_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;
endpackage

// File: rtl/demux_1to8_capture_if.sv
// Input (serial bit + index) and output (word) handshakes of the capture demux.
interface demux_1to8_capture_if #(
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(WIDTH);

  logic             din;
  logic [SEL_W-1:0] sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             dup_err;

  modport master (
    output din, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, dup_err
  );

  modport slave (
    input  din, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, dup_err
  );
endinterface

// File: rtl/demux_1to8_capture_decoder.sv
// Gated binary-to-one-hot decoder producing per-bit write enables.
module demux_decoder #(
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign onehot[i] = en && (sel == SEL_W'(i));
  end
endmodule

// File: rtl/demux_1to8_capture.sv
// Routes serial bits to indexed positions of a word; presents the word once every position is written.
module demux_1to8_capture
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_1to8_capture_if.slave   bus
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] data, mask, we;
  logic             xfer, done, dup, in_rdy, out_vld, handoff;

  assign xfer    = bus.in_valid && in_rdy;
  assign handoff = (state == HOLD) && bus.out_ready;
  // we is already gated by xfer, so done is only meaningful on a transfer
  assign done    = ((mask | we) == '1);

  demux_decoder #(.WIDTH(WIDTH)) u_dec (
    .sel    (bus.sel),
    .en     (xfer),
    .onehot (we)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (xfer && done)    state_nxt = HOLD;
      HOLD:    if (bus.out_ready)   state_nxt = COLLECT;
      default:                      state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_rdy  = 1'b1;
    out_vld = 1'b0;
    case (state)
      COLLECT: begin in_rdy = 1'b1; out_vld = 1'b0; end
      HOLD:    begin in_rdy = 1'b0; out_vld = 1'b1; end
      default: begin in_rdy = 1'b1; out_vld = 1'b0; end
    endcase
  end

  // Rewrites of an already-set position overwrite the bit and flag a pulse next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      mask <= '0;
      dup  <= 1'b0;
    end else begin
      dup <= |(mask & we);
      if (handoff) begin
        data <= '0;
        mask <= '0;
      end else if (xfer) begin
        data <= (data & ~we) | (we & {WIDTH{bus.din}});
        mask <= mask | we;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = data;
  assign bus.dup_err   = dup;
endmodule

// File: tb/tb_demux_1to8_capture.sv
// Directed plus random checks of demux_1to8_capture against a per-position reference model.
module tb_demux_1to8_capture;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  demux_1to8_capture_if #(.WIDTH(W)) bus ();

  demux_1to8_capture #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: which positions have been written this frame and their bit values
  bit m_bits [W];
  bit m_wr   [W];
  bit m_hold;
  bit m_dup;

  function automatic logic [W-1:0] m_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) w[i] = m_bits[i];
    return w;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(m_wr[i]);
    return n;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < W; i++) begin m_bits[i] = 1'b0; m_wr[i] = 1'b0; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs
  task automatic cyc(input bit r, input bit v, input bit d, input logic [2:0] s, input bit o);
    rst = r; bus.in_valid = v; bus.din = d; bus.sel = s; bus.out_ready = o;
    if (r) begin
      m_clear(); m_hold = 0; m_dup = 0;
    end else if (m_hold) begin
      m_dup = 0;
      if (o) begin m_clear(); m_hold = 0; end
    end else if (v) begin
      m_dup = m_wr[s];
      m_bits[s] = d;
      m_wr[s] = 1'b1;
      if (m_count() == W) m_hold = 1;
    end else begin
      m_dup = 0;
    end
    @(posedge clk); #1;
    chk("out_data",  32'(bus.out_data),  32'(m_word()));
    chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
    chk("in_ready",  32'(bus.in_ready),  32'(!m_hold));
    chk("dup_err",   32'(bus.dup_err),   32'(m_dup));
  endtask

  logic [7:0] pat;

  initial begin
    bus.din = 0; bus.sel = '0; bus.in_valid = 0; bus.out_ready = 0;
    m_clear(); m_hold = 0; m_dup = 0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 3, 1);
    chk("rst_data",  32'(bus.out_data), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h1);

    // Ascending positions, back-to-back
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("a5_pre_valid", 32'(bus.out_valid), 32'h0);
      cyc(0, 1, pat[i], 3'(i), 0);
    end
    chk("a5_valid", 32'(bus.out_valid), 32'h1);
    chk("a5_data",  32'(bus.out_data),  32'hA5);
    cyc(0, 0, 0, 0, 1);

    // Descending positions with idle gaps; held until consumed
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 1, pat[i], 3'(i), 0);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("3c_data",  32'(bus.out_data),  32'h3C);
    chk("3c_valid", 32'(bus.out_valid), 32'h1);
    cyc(0, 0, 0, 0, 1);

    // Duplicate write to position 2
    cyc(0, 1, 1, 2, 0);
    chk("dup_first", 32'(bus.dup_err), 32'h0);
    cyc(0, 1, 0, 2, 0);
    chk("dup_pulse", 32'(bus.dup_err), 32'h1);
    cyc(0, 0, 0, 0, 0);
    chk("dup_drop",  32'(bus.dup_err), 32'h0);
    for (int i = 0; i < 8; i++) if (i != 2) cyc(0, 1, 1, 3'(i), 0);
    chk("fb_data", 32'(bus.out_data), 32'hFB);

    // Stall in HOLD with input pressure
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 3'(i), 0);
      chk("stall_data",  32'(bus.out_data), 32'hFB);
      chk("stall_ready", 32'(bus.in_ready), 32'h0);
    end
    cyc(0, 0, 0, 0, 1);
    chk("release_valid", 32'(bus.out_valid), 32'h0);
    chk("release_ready", 32'(bus.in_ready),  32'h1);

    // Partial frame discarded by reset
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 3'(i), 0);
    cyc(1, 0, 0, 0, 0);
    chk("midrst_data",  32'(bus.out_data), 32'h0);
    chk("midrst_ready", 32'(bus.in_ready), 32'h1);
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, pat[i], 3'(i), 0);
      chk("5a_nodup", 32'(bus.dup_err), 32'h0);
    end
    chk("5a_data", 32'(bus.out_data), 32'h5A);

    // Handoff wins over simultaneous input
    cyc(0, 1, 1, 0, 1);
    chk("handoff_data",  32'(bus.out_data),  32'h0);
    chk("handoff_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("fresh_pre_valid", 32'(bus.out_valid), 32'h0);
      cyc(0, 1, 0, 3'(7 - i), 0);
      chk("fresh_nodup", 32'(bus.dup_err), 32'h0);
    end
    chk("fresh_valid", 32'(bus.out_valid), 32'h1);
    cyc(0, 0, 0, 0, 1);

    // Random traffic
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
